// File: rtl/mult_div_unit.sv
// Iterative MIPS multiply/divide unit owning the HI/LO registers; one add/sub step per cycle.
// Optional cancel port enabled by defining MDU_CANCEL_EN.
module mult_div_unit #(
    parameter int DATA_LEN = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [1:0]          op,
    input  logic [DATA_LEN-1:0] in1,
    input  logic [DATA_LEN-1:0] in2,
    input  logic                hi_we,
    input  logic                lo_we,
    input  logic [DATA_LEN-1:0] wr_data,
`ifdef MDU_CANCEL_EN
    input  logic                cancel,
`endif
    output logic                busy,
    output logic                done,
    output logic [DATA_LEN-1:0] hi,
    output logic [DATA_LEN-1:0] lo
);

    localparam int CNT_W = (DATA_LEN > 1) ? $clog2(DATA_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_LEN - 1);
    localparam logic [DATA_LEN-1:0] ZERO_W = {DATA_LEN{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_LOAD = 2'b01,
        ST_ITER = 2'b10,
        ST_FIX  = 2'b11
    } state_t;

    state_t                state_r;
    logic [1:0]            op_r;
    logic [DATA_LEN-1:0]   a_r;
    logic [DATA_LEN-1:0]   b_r;
    logic [DATA_LEN-1:0]   acc_r;
    logic [DATA_LEN-1:0]   q_r;
    logic [CNT_W-1:0]      cnt_r;
    logic                  neg_lo_r;
    logic                  neg_hi_r;

    logic                  cancel_s;
    logic                  sa_s;
    logic                  sb_s;
    logic [DATA_LEN-1:0]   abs_a_s;
    logic [DATA_LEN-1:0]   abs_b_s;
    logic [DATA_LEN:0]     add_s;
    logic [DATA_LEN:0]     shl_s;
    logic [DATA_LEN:0]     sub_s;
    logic [DATA_LEN-1:0]   acc_nx_s;
    logic [DATA_LEN-1:0]   q_nx_s;
    logic [2*DATA_LEN-1:0] prod_s;
    logic [2*DATA_LEN-1:0] prod_fix_s;
    logic [DATA_LEN-1:0]   hi_res_s;
    logic [DATA_LEN-1:0]   lo_res_s;

`ifdef MDU_CANCEL_EN
    assign cancel_s = cancel;
`else
    assign cancel_s = 1'b0;
`endif

    function automatic logic [DATA_LEN-1:0] neg2c(input logic [DATA_LEN-1:0] x);
        return ~x + {{(DATA_LEN-1){1'b0}}, 1'b1};
    endfunction

    function automatic logic [2*DATA_LEN-1:0] neg2c_wide(input logic [2*DATA_LEN-1:0] x);
        return ~x + {{(2*DATA_LEN-1){1'b0}}, 1'b1};
    endfunction

    function automatic logic [DATA_LEN-1:0] abs_val(input logic [DATA_LEN-1:0] x,
                                                    input logic                neg);
        if (neg) begin
            return neg2c(x);
        end else begin
            return x;
        end
    endfunction

    // Operand conditioning, per-cycle step datapath and final sign fix-up
    always_comb begin
        sa_s    = ~op_r[0] & a_r[DATA_LEN-1];
        sb_s    = ~op_r[0] & b_r[DATA_LEN-1];
        abs_a_s = abs_val(a_r, sa_s);
        abs_b_s = abs_val(b_r, sb_s);

        add_s = {1'b0, acc_r} + (q_r[0] ? {1'b0, b_r} : {1'b0, ZERO_W});
        shl_s = {acc_r, q_r[DATA_LEN-1]};
        // acc < divisor always holds, so the top bit of the difference is the borrow
        sub_s = shl_s - {1'b0, b_r};

        if (op_r[1]) begin
            if (sub_s[DATA_LEN]) begin
                acc_nx_s = shl_s[DATA_LEN-1:0];
                q_nx_s   = {q_r[DATA_LEN-2:0], 1'b0};
            end else begin
                acc_nx_s = sub_s[DATA_LEN-1:0];
                q_nx_s   = {q_r[DATA_LEN-2:0], 1'b1};
            end
        end else begin
            acc_nx_s = add_s[DATA_LEN:1];
            q_nx_s   = {add_s[0], q_r[DATA_LEN-1:1]};
        end

        prod_s     = {acc_r, q_r};
        prod_fix_s = neg_lo_r ? neg2c_wide(prod_s) : prod_s;
        if (op_r[1]) begin
            lo_res_s = neg_lo_r ? neg2c(q_r) : q_r;
            hi_res_s = neg_hi_r ? neg2c(acc_r) : acc_r;
        end else begin
            lo_res_s = prod_fix_s[DATA_LEN-1:0];
            hi_res_s = prod_fix_s[2*DATA_LEN-1:DATA_LEN];
        end
    end

    // Control FSM with registered busy/done/HI/LO
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            op_r     <= 2'b00;
            a_r      <= ZERO_W;
            b_r      <= ZERO_W;
            acc_r    <= ZERO_W;
            q_r      <= ZERO_W;
            cnt_r    <= {CNT_W{1'b0}};
            neg_lo_r <= 1'b0;
            neg_hi_r <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            hi       <= ZERO_W;
            lo       <= ZERO_W;
        end else begin
            done <= 1'b0;
            if (cancel_s && busy) begin
                state_r <= ST_IDLE;
                busy    <= 1'b0;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        if (hi_we) begin
                            hi <= wr_data;
                        end
                        if (lo_we) begin
                            lo <= wr_data;
                        end
                        if (start) begin
                            op_r    <= op;
                            a_r     <= in1;
                            b_r     <= in2;
                            busy    <= 1'b1;
                            state_r <= ST_LOAD;
                        end
                    end
                    ST_LOAD: begin
                        // q holds the multiplier or dividend; b holds the multiplicand or divisor
                        q_r      <= op_r[1] ? abs_a_s : abs_b_s;
                        b_r      <= op_r[1] ? abs_b_s : abs_a_s;
                        neg_lo_r <= sa_s ^ sb_s;
                        neg_hi_r <= op_r[1] ? sa_s : (sa_s ^ sb_s);
                        acc_r    <= ZERO_W;
                        cnt_r    <= {CNT_W{1'b0}};
                        state_r  <= ST_ITER;
                    end
                    ST_ITER: begin
                        acc_r <= acc_nx_s;
                        q_r   <= q_nx_s;
                        cnt_r <= cnt_r + CNT_ONE;
                        if (cnt_r == CNT_LAST) begin
                            state_r <= ST_FIX;
                        end
                    end
                    ST_FIX: begin
                        hi      <= hi_res_s;
                        lo      <= lo_res_s;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                    default: begin
                        state_r <= ST_IDLE;
                        busy    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: cycle model of busy/done/HI/LO plus literal checks.
module tb_mult_div_unit;

    localparam int DL = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [1:0]    op;
    logic [DL-1:0] in1;
    logic [DL-1:0] in2;
    logic          hi_we;
    logic          lo_we;
    logic [DL-1:0] wr_data;
    logic          cancel;
    logic          busy;
    logic          done;
    logic [DL-1:0] hi;
    logic [DL-1:0] lo;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mult_div_unit #(.DATA_LEN(DL)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .op      (op),
        .in1     (in1),
        .in2     (in2),
        .hi_we   (hi_we),
        .lo_we   (lo_we),
        .wr_data (wr_data),
`ifdef MDU_CANCEL_EN
        .cancel  (cancel),
`endif
        .busy    (busy),
        .done    (done),
        .hi      (hi),
        .lo      (lo)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Architectural result {HI, LO} of an op, from plain integer arithmetic
    function automatic logic [63:0] calc(input logic [1:0] o, input logic [31:0] a,
                                         input logic [31:0] b);
        logic [63:0] p;
        int          sa;
        int          sb;
        logic [31:0] h;
        logic [31:0] l;
        sa = a;
        sb = b;
        p  = 64'd0;
        h  = 32'd0;
        l  = 32'd0;
        case (o)
            2'b00: begin
                p = 64'(longint'(sa) * longint'(sb));
                h = p[63:32];
                l = p[31:0];
            end
            2'b01: begin
                p = {32'd0, a} * {32'd0, b};
                h = p[63:32];
                l = p[31:0];
            end
            2'b10: begin
                if (b == 32'd0) begin
                    h = a;
                    l = a[31] ? 32'd1 : 32'hFFFF_FFFF;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    h = 32'd0;
                    l = 32'h8000_0000;
                end else begin
                    l = 32'(sa / sb);
                    h = 32'(sa % sb);
                end
            end
            default: begin
                if (b == 32'd0) begin
                    h = a;
                    l = 32'hFFFF_FFFF;
                end else begin
                    l = a / b;
                    h = a % b;
                end
            end
        endcase
        return {h, l};
    endfunction

    logic          m_valid = 1'b0;
    logic          m_busy;
    logic          m_done;
    logic [DL-1:0] m_hi;
    logic [DL-1:0] m_lo;
    logic [63:0]   m_pend;
    int            m_rem;

    // Behavioural model: op result lands DL+2 edges after the start edge
    always @(posedge clk) begin
        if (!rst_n) begin
            m_valid <= 1'b1;
            m_busy  <= 1'b0;
            m_done  <= 1'b0;
            m_hi    <= '0;
            m_lo    <= '0;
            m_rem   <= 0;
        end else begin
            m_done <= 1'b0;
            if (!m_busy) begin
                if (hi_we) m_hi <= wr_data;
                if (lo_we) m_lo <= wr_data;
                if (start) begin
                    m_pend <= calc(op, in1, in2);
                    m_busy <= 1'b1;
                    m_rem  <= DL + 2;
                end
`ifdef MDU_CANCEL_EN
            end else if (cancel) begin
                m_busy <= 1'b0;
`endif
            end else if (m_rem == 1) begin
                m_hi   <= m_pend[63:32];
                m_lo   <= m_pend[31:0];
                m_done <= 1'b1;
                m_busy <= 1'b0;
            end else begin
                m_rem <= m_rem - 1;
            end
        end
    end

    // Every-cycle comparison of DUT outputs against the model
    always @(negedge clk) begin
        if (m_valid) begin
            chk("busy", 64'(busy), 64'(m_busy));
            chk("done", 64'(done), 64'(m_done));
            chk("hi", 64'(hi), 64'(m_hi));
            chk("lo", 64'(lo), 64'(m_lo));
        end
    end

    task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
        int n;
        @(posedge clk); #1;
        op = o; in1 = a; in2 = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        while (!done && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk({name, "_latency"}, 64'(n), 64'd34);
        chk({name, "_hi"}, 64'(hi), 64'(eh));
        chk({name, "_lo"}, 64'(lo), 64'(el));
    endtask

    task automatic count_done(input int cycles, output int cnt);
        cnt = 0;
        repeat (cycles) begin
            @(posedge clk); #1;
            if (done) cnt++;
        end
    endtask

    task automatic write_hilo(input logic we_h, input logic we_l, input logic [31:0] d);
        @(posedge clk); #1;
        hi_we = we_h; lo_we = we_l; wr_data = d;
        @(posedge clk); #1;
        hi_we = 1'b0; lo_we = 1'b0;
    endtask

    initial begin
        int d;
        rst_n = 1'b0; start = 1'b0; op = 2'b00; in1 = '0; in2 = '0;
        hi_we = 1'b0; lo_we = 1'b0; wr_data = '0; cancel = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_hi", 64'(hi), 64'd0);
        chk("rst_lo", 64'(lo), 64'd0);
        rst_n = 1'b1;

        run_op("mult_m3x7", 2'b00, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        run_op("div_m7d2", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("divu_100d7", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14);
        run_op("divu_5d0", 2'b11, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF);
        run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);
        run_op("div_m9d0", 2'b10, 32'hFFFF_FFF7, 32'd0, 32'hFFFF_FFF7, 32'd1);
        run_op("div_7dm2", 2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD);
        run_op("mult_mm", 2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
        run_op("multu_mix", 2'b01, 32'h1234_5678, 32'h0000_1000, 32'h0000_0123, 32'h4567_8000);

        // writes and start ignored while busy; only one done pulse
        @(posedge clk); #1;
        op = 2'b11; in1 = 32'd100; in2 = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        hi_we = 1'b1; wr_data = 32'h1234; start = 1'b1; op = 2'b01; in1 = 32'd5; in2 = 32'd5;
        @(posedge clk); #1;
        hi_we = 1'b0; start = 1'b0;
        count_done(45, d);
        chk("busy_ignore_done_count", 64'(d), 64'd1);
        chk("busy_ignore_hi", 64'(hi), 64'd2);
        chk("busy_ignore_lo", 64'(lo), 64'd14);

        write_hilo(1'b1, 1'b0, 32'h1234);
        chk("idle_write_hi", 64'(hi), 64'h1234);
        chk("idle_write_lo_kept", 64'(lo), 64'd14);
        write_hilo(1'b1, 1'b1, 32'hCAFE_F00D);
        chk("idle_write_both", 64'({hi, lo}), 64'hCAFE_F00D_CAFE_F00D);

        // write and start together: op result overwrites the write
        @(posedge clk); #1;
        hi_we = 1'b1; wr_data = 32'hDEAD_BEEF; op = 2'b01; in1 = 32'd6; in2 = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        hi_we = 1'b0; start = 1'b0;
        chk("start_we_hi_first", 64'(hi), 64'hDEAD_BEEF);
        count_done(40, d);
        chk("start_we_done", 64'(d), 64'd1);
        chk("start_we_lo", 64'(lo), 64'd42);
        chk("start_we_hi_final", 64'(hi), 64'd0);

`ifdef MDU_CANCEL_EN
        write_hilo(1'b1, 1'b1, 32'hAAAA_5555);
        @(posedge clk); #1;
        op = 2'b01; in1 = 32'd3; in2 = 32'd4; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        cancel = 1'b1;
        @(posedge clk); #1;
        cancel = 1'b0;
        @(posedge clk); #1;
        chk("cancel_busy", 64'(busy), 64'd0);
        count_done(40, d);
        chk("cancel_no_done", 64'(d), 64'd0);
        chk("cancel_hi", 64'(hi), 64'hAAAA_5555);
        chk("cancel_lo", 64'(lo), 64'hAAAA_5555);
        run_op("after_cancel", 2'b01, 32'd3, 32'd4, 32'd0, 32'd12);
`endif

        // reset at cycle 10 of a MULT
        @(posedge clk); #1;
        op = 2'b00; in1 = 32'd9; in2 = 32'd9; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("midop_rst_busy", 64'(busy), 64'd0);
        chk("midop_rst_hi", 64'(hi), 64'd0);
        chk("midop_rst_lo", 64'(lo), 64'd0);
        count_done(40, d);
        chk("midop_rst_no_done", 64'(d), 64'd0);

        run_op("post_rst_mult", 2'b00, 32'hFFFF_FFFF, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFB);

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
